// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the transmit and receive halves of
// the board serial link. The receiver imports this same package, so the state
// encoding and data width must stay in step on both sides.
// The PARITY state is always present in the enum so the encoding is identical
// whether or not UART_TX_PARITY_EN is defined for a given build.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int   UART_DATA_W     = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic uart_even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous FIFO between the bus-side byte port and the
// serial shifter. DEPTH must be a power of two, so the pointers wrap on their
// own. A push into a full FIFO and a pop from an empty FIFO are both ignored.
// The occupancy counter is the single source of full/empty, which avoids the
// usual extra pointer bit.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == COUNT_FULL);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents of empty slots are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_unit.sv
// uart_tx_unit: byte-serial UART transmitter, 8N1 LSB first.
// Optional feature macro: UART_TX_PARITY_EN adds an even parity bit (8E1).
//
// The bus side pushes bytes through a valid/ready port into uart_tx_fifo.
// The FSM pops the FIFO head while IDLE and shifts it out at WAIT clocks per
// bit. uart_tx is registered from the current state, so the line lags the
// state register by one clock: a byte accepted at edge N into an empty FIFO
// is popped at edge N+1 and the start bit appears at edge N+2. Every state
// still lasts exactly WAIT clocks, so the frame is 10*WAIT (11*WAIT with
// parity) and back-to-back frames are separated by one extra IDLE clock.
//
// state  | meaning
// IDLE   | line high, pop FIFO head into the shifter when available
// START  | line low for WAIT clocks
// DATA   | line = shift[0] for WAIT clocks per bit, 8 bits LSB first
// PARITY | line = even parity of the byte (only with UART_TX_PARITY_EN)
// STOP   | line high for WAIT clocks, then back to IDLE
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int WAIT  = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [UART_DATA_W-1:0]   in_data,
  output logic                     in_ready,
  output logic                     uart_tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int TW = $clog2(WAIT);
  localparam logic [TW-1:0] T_LAST = TW'(WAIT - 1);
  localparam int BW = $clog2(UART_DATA_W);
  localparam logic [BW-1:0] B_LAST = BW'(UART_DATA_W - 1);

  uart_state_t            state;
  logic [TW-1:0]          timer;
  logic [BW-1:0]          bit_cnt;
  logic [UART_DATA_W-1:0] shift;
  logic                   tx_q;
  logic                   timer_done;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   fifo_push;
  logic [UART_DATA_W-1:0] fifo_head;

`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif

  // in_ready is decided from registered occupancy only, so a pop on the same
  // edge never lets a push into a full FIFO.
  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && in_ready;
  assign fifo_pop   = (state == IDLE) && !fifo_empty;
  assign timer_done = (timer == T_LAST);
  assign uart_tx    = tx_q;
  assign busy       = (state != IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // Frame sequencer: state, bit timer, bit counter, shifter and registered line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx_q    <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_q    <= UART_IDLE_LEVEL;
          timer   <= '0;
          bit_cnt <= '0;
          if (!fifo_empty) begin
            shift <= fifo_head;
`ifdef UART_TX_PARITY_EN
            par_q <= uart_even_parity(fifo_head);
`endif
            state <= START;
          end
        end

        START: begin
          tx_q <= 1'b0;
          if (timer_done) begin
            timer <= '0;
            state <= DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DATA: begin
          tx_q <= shift[0];
          if (timer_done) begin
            timer <= '0;
            shift <= shift >> 1;
            if (bit_cnt == B_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_q <= par_q;
          if (timer_done) begin
            timer <= '0;
            state <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif

        STOP: begin
          tx_q <= UART_IDLE_LEVEL;
          if (timer_done) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          tx_q    <= UART_IDLE_LEVEL;
          timer   <= '0;
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit: a driver feeds bytes through the valid/ready port
// and pushes every accepted byte into an expected queue; an independent line
// monitor decodes uart_tx like a receiver (sampling mid-bit) and checks each
// decoded frame against the queue head.
module tb_uart_tx_unit;

  localparam int WAIT  = 8;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       uart_tx;
  logic       busy;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  int         fall_cyc[$];
  int         acc_cyc[$];
  int         acc_cnt[$];
  int         acc_rdy[$];

  uart_tx_unit #(.WAIT(WAIT), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .count    (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive every byte of src_q with in_valid held; junk data while not ready.
  task automatic drive_all(input int budget);
    int  n = 0;
    logic rdy;
    acc_cyc.delete();
    acc_cnt.delete();
    acc_rdy.delete();
    @(negedge clk);
    while (src_q.size() > 0 && n < budget) begin
      rdy      = in_ready;
      in_valid = 1'b1;
      in_data  = rdy ? src_q[0] : 8'($urandom);
      @(negedge clk);
      n++;
      if (rdy) begin
        exp_q.push_back(src_q.pop_front());
        acc_cyc.push_back(cyc);
        acc_cnt.push_back(int'(count));
        acc_rdy.push_back(int'(in_ready));
      end
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (src_q.size() > 0) chk("drive_timeout", src_q.size(), 0);
    src_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) chk("idle_timeout", exp_q.size(), 0);
    repeat (WAIT + 2) @(negedge clk);
  endtask

  task automatic mon_wait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (reset) ab = 1'b1;
    end
  endtask

  // Line monitor: behaves like a receiver, frame boundaries from the line only.
  initial begin
    bit         prev = 1'b1;
    bit         ab;
    logic       sb;
    logic       pb;
    logic       eb;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else if (prev && !uart_tx) begin
        fall_cyc.push_back(cyc);
        ab = 1'b0;
        mon_wait(WAIT / 2, ab);
        sb = uart_tx;
        for (int i = 0; i < 8; i++) begin
          mon_wait(WAIT, ab);
          d[i] = uart_tx;
        end
        pb = 1'b0;
`ifdef UART_TX_PARITY_EN
        mon_wait(WAIT, ab);
        pb = uart_tx;
`endif
        mon_wait(WAIT, ab);
        eb = uart_tx;
        if (!ab) begin
          chk("start_bit", sb, 0);
          chk("stop_bit", eb, 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", d, 32'hFFFF_FFFF);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("frame_data", d, e);
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", pb, $countones(e) % 2);
`endif
          end
        end
        prev = 1'b1;
      end else begin
        prev = uart_tx;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    int bad;
    int nf;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #10 reset = 1'b0;

    // Quiet line after reset
    chk("reset_count", count, 0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i % 10 == 0) begin
        chk("idle_tx", uart_tx, 1);
        chk("idle_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
      end
    end

    // Single byte, latency from accept to start bit
    fall_cyc.delete();
    src_q.push_back(8'h0F);
    drive_all(100);
    wait_idle(2000);
    chk("single_frames", fall_cyc.size(), 1);
    if (fall_cyc.size() == 1 && acc_cyc.size() == 1)
      chk("latency", fall_cyc[0] - acc_cyc[0], 2);

    // Four consecutive pushes: one push+pop edge, back-to-back frames
    fall_cyc.delete();
    src_q = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    drive_all(100);
    chk("burst_accepts", acc_cyc.size(), 4);
    if (acc_cnt.size() == 4) begin
      chk("burst_cnt0", acc_cnt[0], 1);
      chk("burst_cnt1_pushpop", acc_cnt[1], 1);
      chk("burst_cnt2", acc_cnt[2], 2);
      chk("burst_cnt3", acc_cnt[3], 3);
      chk("burst_consecutive", acc_cyc[3] - acc_cyc[0], 3);
    end
    chk("burst_busy", busy, 1);
    wait_idle(2000);
    chk("burst_frames", fall_cyc.size(), 4);
    if (fall_cyc.size() == 4) begin
      chk("burst_latency", fall_cyc[0] - acc_cyc[0], 2);
      for (int i = 0; i < 3; i++)
        chk("burst_gap", fall_cyc[i+1] - fall_cyc[i], FRAME * WAIT + 1);
    end
    chk("burst_end_count", count, 0);
    chk("burst_end_busy", busy, 0);

    // Six bytes with in_valid held: fills, stalls, resumes after a pop
    src_q.delete();
    for (int i = 0; i < 6; i++) src_q.push_back(8'($urandom));
    drive_all(2000);
    chk("full_accepts", acc_cyc.size(), 6);
    if (acc_cyc.size() == 6) begin
      chk("full_cnt3", acc_cnt[3], 3);
      chk("full_cnt4", acc_cnt[4], 4);
      chk("full_rdy4", acc_rdy[4], 0);
      chk("full_rdy3", acc_rdy[3], 1);
      chk("full_cnt5", acc_cnt[5], 4);
      chk("full_rdy5", acc_rdy[5], 0);
      chk("full_stall", acc_cyc[5] - acc_cyc[0], FRAME * WAIT + 3);
    end
    wait_idle(3000);
    chk("full_end_count", count, 0);

    // Random bursts with random gaps
    for (int r = 0; r < 4; r++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) src_q.push_back(8'($urandom));
      drive_all(3000);
      repeat ($urandom_range(0, 120)) @(negedge clk);
    end
    wait_idle(4000);

    // Reset in the middle of data bit 3 of 0xA3 with two more queued
    src_q = '{8'hA3, 8'($urandom), 8'($urandom)};
    drive_all(100);
    target = acc_cyc.size() > 0 ? acc_cyc[0] + 2 + 4 * WAIT + WAIT / 2 : cyc;
    for (int n = 0; n < 200 && cyc < target; n++) @(negedge clk);
    chk("mid_bit3", uart_tx, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_tx", uart_tx, 1);
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    nf  = fall_cyc.size();
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    chk("post_rst_frames", fall_cyc.size() - nf, 0);
    chk("post_rst_count", count, 0);
    src_q.push_back(8'h3C);
    drive_all(100);
    wait_idle(2000);

    // Parity patterns and frame length
    fall_cyc.delete();
    src_q = '{8'h0F, 8'h07};
    drive_all(100);
    wait_idle(2000);
    chk("par_frames", fall_cyc.size(), 2);
    if (fall_cyc.size() == 2)
      chk("par_gap", fall_cyc[1] - fall_cyc[0], FRAME * WAIT + 1);

    chk("end_queue", exp_q.size(), 0);
    chk("end_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
